lsu_dmem_master: RTL and testbench
==================================

// Module: lsu_dmem_master
// PURPOSE
//  CPU-side load/store initiator for the data memory. Accepts one load/store per handshake
//  from the execute stage. Checks the address against the DMEM window. Splits accesses that
//  cross a word boundary into two word accesses with byte enables. Reassembles load data and
//  sign- or zero-extends it per fn3. Returns exactly one response per accepted request.
// PARAMETERS
//  DMEM_BASE  32'h8000_2000  byte address of first DMEM location
//  DMEM_SIZE  16384          DMEM window size in bytes
//  TIMEOUT    255            max cycles waiting for mem_gnt/mem_rvalid before error (>=1)
// PORTS
//  clk          in   1   single core clock, all logic on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted when req_valid&&req_ready
//  req_we       in   1   1=store, 0=load
//  req_fn3      in   3   RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, LSB-aligned
//  resp_valid   out  1   one-cycle response pulse
//  resp_err     out  1   valid with resp_valid: bad fn3, out of range, or timeout
//  resp_rdata   out  32  extended load data (0 for stores/errors); held until next resp
//  mem_req      out  1   memory access request, held until mem_gnt
//  mem_we       out  1   write strobe
//  mem_addr     out  32  word-aligned byte address
//  mem_be       out  4   byte enables, bit i = byte lane i
//  mem_wdata    out  32  lane-aligned write data
//  mem_gnt      in   1   request taken this cycle
//  mem_rvalid   in   1   read data valid (loads only, >=1 cycle after gnt)
//  mem_rdata    in   32  read word
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, timer=0; req_ready=1; all other outputs 0.
//  FSM: IDLE -> ISSUE0 -> [WAIT0] -> [ISSUE1 -> [WAIT1]] -> RESP -> IDLE. WAITx only for loads.
//  IDLE: req_ready=1. On accept, register we/fn3/addr/wdata.
//   Error path: ->RESP with resp_err=1 and no mem_req if either holds:
//    - invalid fn3: load 011/110/111, store >=011
//    - range: addr<DMEM_BASE or addr-DMEM_BASE+size>DMEM_SIZE
//  Size: 1/2/4 bytes. off=addr[1:0]. m=((1<<size)-1)<<off, 8 bits wide. split = |m[7:4].
//  Access 0: mem_addr={addr[31:2],2'b00}, mem_be=m[3:0], mem_wdata=wdata<<(8*off).
//  Access 1 (split only): mem_addr=access0+4, mem_be=m[7:4], mem_wdata=wdata>>(8*(4-off)).
//  ISSUEx: mem_req=1, addr/be/wdata/we stable until mem_gnt.
//   On gnt: load -> WAITx; store -> ISSUE1 if split pending, else RESP.
//  WAITx: on mem_rvalid latch rdata word x -> ISSUE1 if split pending, else RESP.
//   mem_rvalid outside WAITx ignored; mem_gnt outside ISSUEx ignored.
//  Timer: cleared on each ISSUE/WAIT entry, +1 per cycle there.
//   At TIMEOUT -> RESP with resp_err=1, dropping mem_req. Partial store stays partial.
//  Load assembly: {word1,word0}>>(8*off), low size bytes. LB/LH sign-extend from top byte.
//   LBU/LHU zero-extend. Unused word1 = 0.
//  RESP: resp_valid=1 for exactly one cycle, req_ready=0. Next cycle IDLE.
//   resp_err/resp_rdata registered, valid with the pulse; resp_rdata held afterwards.
//  Latency, accept at edge T, gnt same cycle as req, rvalid one cycle after gnt:
//   aligned load resp_valid at T+3; aligned store at T+2; error at T+1; split load T+5.
//  One outstanding request only; no back-to-back accept during RESP.
// TESTING
//  1 LW 0x8000_2010, gnt immediate, rvalid next cycle rdata=0xDEADBEEF:
//    resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at T+3.
//  2 LB 0x8000_2003, word 0x80123456 -> 0xFFFFFF80.
//    LBU same address -> 0x00000080, mem_be=4'b1000.
//  3 SW 0x8000_2006 wdata 0x11223344:
//    access0 addr 0x8000_2004 be 1100 wdata 0x33440000.
//    access1 addr 0x8000_2008 be 0011 wdata 0x00001122.
//  4 LH 0x8000_2007, words 0xAB000000 then 0x000000CD -> 0xFFFFCDAB.
//    mem_gnt held low 3 cycles: mem_req/addr stable throughout.
//  5 LW 0x8000_0000 (out of range), and SB with fn3=011:
//    resp_err=1 at T+1, mem_req never asserted.
//  6 mem_gnt never asserted:
//    resp_err=1 after TIMEOUT cycles, then mem_req=0.
//    rst_n low during WAIT0: all outputs 0 immediately, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_dmem_master.sv
// -----------------------------------------------------------------------------
// lsu_dmem_master
// CPU-side load/store initiator for the data memory. Takes one load/store per
// handshake, rejects bad funct3 codes and addresses outside the DMEM window,
// splits word-crossing accesses into two word accesses with byte enables,
// reassembles and sign/zero-extends load data, and returns exactly one
// response per accepted request.
//
// Ports
//   clk, rst_n                 core clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake from the execute stage
//   req_we/req_fn3             1=store/0=load, RV32 funct3 (size + signedness)
//   req_addr/req_wdata         byte address, LSB-aligned store data
//   resp_valid                 one-cycle response pulse
//   resp_err                   valid with resp_valid: bad fn3, range or timeout
//   resp_rdata                 extended load data, held until the next response
//   mem_req/mem_gnt            memory request, held until granted
//   mem_we/mem_addr/mem_be     write strobe, word-aligned address, lane enables
//   mem_wdata                  lane-aligned write data
//   mem_rvalid/mem_rdata       read word return (loads only)
// -----------------------------------------------------------------------------
module lsu_dmem_master #(
    parameter logic [31:0] DMEM_BASE = 32'h8000_2000,
    parameter int unsigned DMEM_SIZE = 16384,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_fn3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE0, S_WAIT0, S_ISSUE1, S_WAIT1, S_RESP
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          we_q;
    logic [2:0]    fn3_q;
    logic [31:0]   addr_q, wdata_q;
    logic [31:0]   word0_q, word0_d, word1_q, word1_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    // ---- checks on the incoming request (decided in IDLE) --------------------
    logic [2:0]  in_size;
    logic        in_fn3_ok, in_range_ok;
    logic [32:0] in_end;

    always_comb begin
        case (req_fn3[1:0])
            2'b00:   in_size = 3'd1;
            2'b01:   in_size = 3'd2;
            default: in_size = 3'd4;
        endcase
    end

    assign in_fn3_ok = req_we ? (req_fn3 inside {3'b000, 3'b001, 3'b010})
                              : (req_fn3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    // 33-bit arithmetic so an access running past 2^32 cannot wrap back in.
    assign in_end      = {1'b0, req_addr} - {1'b0, DMEM_BASE} + 33'(in_size);
    assign in_range_ok = (req_addr >= DMEM_BASE) && (in_end <= 33'(DMEM_SIZE));

    // ---- lane mapping of the registered request ------------------------------
    logic [1:0]  off;
    logic [3:0]  size_mask;
    logic [7:0]  mask;
    logic        split;
    logic [31:0] base_addr, wdata0, wdata1;

    assign off = addr_q[1:0];

    always_comb begin
        case (fn3_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Byte mask across two adjacent words; any bit in the upper word means split.
    assign mask      = {4'b0000, size_mask} << off;
    assign split     = |mask[7:4];
    assign base_addr = {addr_q[31:2], 2'b00};
    assign wdata0    = wdata_q << {off, 3'b000};
    // Shift by 32 when off=0 yields zero; access 1 is not issued in that case.
    assign wdata1    = wdata_q >> {3'd4 - {1'b0, off}, 3'b000};

    // ---- load reassembly ----------------------------------------------------
    // The word arriving this cycle is used directly so the result can be
    // registered on the same edge that enters RESP.
    logic [31:0] load_w0, load_w1, load_word, load_ext;

    assign load_w0   = (state_q == S_WAIT0) ? mem_rdata : word0_q;
    assign load_w1   = (state_q == S_WAIT1) ? mem_rdata : word1_q;
    assign load_word = 32'({load_w1, load_w0} >> {off, 3'b000});

    always_comb begin
        case (fn3_q)
            3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b100:  load_ext = {24'd0, load_word[7:0]};
            3'b101:  load_ext = {16'd0, load_word[15:0]};
            default: load_ext = load_word;
        endcase
    end

    // ---- FSM next state and outputs -----------------------------------------
    logic timer_hit;
    assign timer_hit = (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every variable assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        word0_d    = word0_q;
        word1_d    = word1_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;

        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    timer_d = '0;
                    word0_d = '0;
                    word1_d = '0;
                    if (!in_fn3_ok || !in_range_ok) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = S_ISSUE0;
                    end
                end
            end

            S_ISSUE0, S_ISSUE1: begin
                mem_req   = 1'b1;
                mem_addr  = (state_q == S_ISSUE1) ? base_addr + 32'd4 : base_addr;
                mem_be    = (state_q == S_ISSUE1) ? mask[7:4] : mask[3:0];
                mem_wdata = (state_q == S_ISSUE1) ? wdata1 : wdata0;
                if (mem_gnt) begin
                    timer_d = '0;
                    if (!we_q) begin
                        state_d = (state_q == S_ISSUE0) ? S_WAIT0 : S_WAIT1;
                    end else if (state_q == S_ISSUE0 && split) begin
                        state_d = S_ISSUE1;
                    end else begin
                        state_d = S_RESP;
                        err_d   = 1'b0;
                        rdata_d = '0;
                    end
                end else if (timer_hit) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_WAIT0, S_WAIT1: begin
                if (mem_rvalid) begin
                    timer_d = '0;
                    if (state_q == S_WAIT0) word0_d = mem_rdata;
                    else                    word1_d = mem_rdata;
                    if (state_q == S_WAIT0 && split) begin
                        state_d = S_ISSUE1;
                    end else begin
                        state_d = S_RESP;
                        err_d   = 1'b0;
                        rdata_d = load_ext;
                    end
                end else if (timer_hit) begin
                    state_d = S_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign mem_we     = mem_req & we_q;
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = rdata_q;

    // ---- state registers ----------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset as well, so resp_rdata and the
        // memory-side outputs read zero straight out of reset.
        if (!rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            we_q    <= 1'b0;
            fn3_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word0_q <= '0;
            word1_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            timer_q <= timer_d;
            word0_q <= word0_d;
            word1_q <= word1_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                fn3_q   <= req_fn3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_dmem_master
// Directed and randomized load/store traffic against lsu_dmem_master. A
// byte-addressed reference memory predicts load results, access lists and
// response latency; a memory responder process grants requests after a
// programmable delay and returns read data after a programmable delay.
// -----------------------------------------------------------------------------
module tb_lsu_dmem_master;

    localparam logic [31:0] BASE  = 32'h8000_2000;
    localparam int          SIZE  = 16384;
    localparam int          TMO   = 255;
    localparam int          NEVER = 100000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_fn3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    lsu_dmem_master #(.DMEM_BASE(BASE), .DMEM_SIZE(SIZE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_fn3(req_fn3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } acc_t;

    acc_t       acc_q[$];                 // granted accesses, in order
    bit [7:0]   mem_bytes [bit [31:0]];   // responder's memory
    bit [7:0]   ref_bytes [bit [31:0]];   // reference model's memory
    int         gnt_delay   = 0;
    int         rv_delay    = 0;
    int         req_cnt     = 0;          // cycles with mem_req high
    int         stable_viol = 0;
    int         acc_base    = 0;
    int         req_base    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit [7:0] init_byte(input bit [31:0] a);
        return 8'(a ^ (a >> 8) ^ 32'h5A);
    endfunction

    function automatic bit [7:0] mem_rd(input bit [31:0] a);
        return mem_bytes.exists(a) ? mem_bytes[a] : init_byte(a);
    endfunction

    function automatic bit [7:0] ref_rd(input bit [31:0] a);
        return ref_bytes.exists(a) ? ref_bytes[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] read_word(input logic [31:0] a);
        logic [31:0] w;
        for (int l = 0; l < 4; l++) w[8*l +: 8] = mem_rd(a + 32'(l));
        return w;
    endfunction

    task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
        for (int l = 0; l < 4; l++) begin
            mem_bytes[a + 32'(l)] = w[8*l +: 8];
            ref_bytes[a + 32'(l)] = w[8*l +: 8];
        end
    endtask

    function automatic int size_of(input logic [2:0] fn3);
        case (fn3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit fn3_ok(input logic we, input logic [2:0] fn3);
        if (we) return fn3 == 3'd0 || fn3 == 3'd1 || fn3 == 3'd2;
        return fn3 == 3'd0 || fn3 == 3'd1 || fn3 == 3'd2 || fn3 == 3'd4 || fn3 == 3'd5;
    endfunction

    // Memory responder: decides grants and read returns at each falling edge.
    initial begin : responder
        bit          req_prev = 1'b0;
        bit          gnt_prev = 1'b0;
        acc_t        cur;
        int          stall    = 0;
        bit          rv_pend  = 1'b0;
        int          rv_cnt   = 0;
        logic [31:0] rv_addr  = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        cur = '{32'd0, 4'd0, 32'd0, 1'b0};
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (!rst_n) begin
                mem_gnt = 1'b0; req_prev = 1'b0; gnt_prev = 1'b0;
                stall = 0; rv_pend = 1'b0;
            end else begin
                if (req_prev && gnt_prev) begin
                    acc_q.push_back(cur);
                    if (cur.we) begin
                        for (int l = 0; l < 4; l++)
                            if (cur.be[l]) mem_bytes[cur.addr + 32'(l)] = cur.wdata[8*l +: 8];
                    end else begin
                        rv_pend = 1'b1; rv_cnt = rv_delay; rv_addr = cur.addr;
                    end
                    stall = 0;
                end else if (req_prev && !resp_valid) begin
                    if (!(mem_req && mem_addr === cur.addr && mem_be === cur.be &&
                          mem_wdata === cur.wdata && mem_we === cur.we))
                        stable_viol++;
                end
                if (rv_pend) begin
                    if (rv_cnt == 0) begin
                        mem_rvalid = 1'b1; mem_rdata = read_word(rv_addr); rv_pend = 1'b0;
                    end else begin
                        rv_cnt--;
                    end
                end
                mem_gnt = 1'b0;
                if (mem_req) begin
                    req_cnt++;
                    cur = '{mem_addr, mem_be, mem_wdata, mem_we};
                    if (stall >= gnt_delay) mem_gnt = 1'b1;
                    else stall++;
                end else begin
                    stall = 0;
                end
                req_prev = mem_req;
                gnt_prev = mem_gnt;
            end
        end
    end

    // One request; returns the response and the latency in clock edges from
    // the accepting edge to the first edge that samples resp_valid high.
    task automatic do_req(input logic we, input logic [2:0] fn3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic err,
                          output logic [31:0] rdata, output int lat);
        int cyc;
        bit got;
        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_fn3 = fn3; req_addr = addr; req_wdata = wdata;
        acc_base = acc_q.size();
        req_base = req_cnt;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_fn3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        got = 1'b0; cyc = 0; err = 1'bx; rdata = 'x; lat = -1;
        while (!got && cyc < 1000) begin
            if (resp_valid) begin
                got = 1'b1; err = resp_err; rdata = resp_rdata; lat = cyc + 1;
                check("ready_low_in_resp", 32'(req_ready), 32'd0);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("resp_seen", 32'(got), 32'd1);
    endtask

    // Reference model: predicts error, latency, access list and load data
    // from byte-level rules, and applies stores to the reference memory.
    task automatic check_model(input string tag, input logic we, input logic [2:0] fn3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic err, input logic [31:0] rdata, input int lat);
        int          sz, n_exp, exp_lat;
        longint      a64;
        bit          exp_err;
        logic [31:0] first_w, last_w, w, exp_rd, lane_mask, exp_wd;
        logic [3:0]  exp_be;
        acc_t        got;
        sz      = size_of(fn3);
        a64     = addr;
        exp_err = !fn3_ok(we, fn3) || a64 < longint'(BASE) ||
                  (a64 - longint'(BASE) + sz > SIZE);
        first_w = addr & ~32'd3;
        last_w  = (addr + 32'(sz - 1)) & ~32'd3;
        n_exp   = exp_err ? 0 : ((first_w == last_w) ? 1 : 2);
        exp_lat = n_exp * (gnt_delay + 1 + (we ? 0 : rv_delay + 1)) + 1;
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_nacc"}, 32'(acc_q.size() - acc_base), 32'(n_exp));
        for (int k = 0; k < n_exp && acc_base + k < acc_q.size(); k++) begin
            w = first_w + 32'(4 * k);
            exp_be = '0; exp_wd = '0; lane_mask = '0;
            for (int i = 0; i < sz; i++)
                if (((addr + 32'(i)) & ~32'd3) == w) begin
                    exp_be[(addr + 32'(i)) & 32'd3] = 1'b1;
                    exp_wd[8*((addr + 32'(i)) & 32'd3) +: 8] = wdata[8*i +: 8];
                    lane_mask[8*((addr + 32'(i)) & 32'd3) +: 8] = 8'hFF;
                end
            got = acc_q[acc_base + k];
            check({tag, "_acc_addr"}, got.addr, w);
            check({tag, "_acc_be"}, 32'(got.be), 32'(exp_be));
            check({tag, "_acc_we"}, 32'(got.we), 32'(we));
            if (we) check({tag, "_acc_wdata"}, got.wdata & lane_mask, exp_wd);
        end
        exp_rd = '0;
        if (!exp_err) begin
            if (we) begin
                for (int i = 0; i < sz; i++) ref_bytes[addr + 32'(i)] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) exp_rd[8*i +: 8] = ref_rd(addr + 32'(i));
                if (!fn3[2] && sz < 4 && exp_rd[8*sz-1])
                    for (int i = sz; i < 4; i++) exp_rd[8*i +: 8] = 8'hFF;
            end
        end
        check({tag, "_rdata"}, rdata, exp_rd);
    endtask

    initial begin : stimulus
        logic        e, we;
        logic [2:0]  f;
        logic [31:0] d, a, wd;
        int          l;
        req_valid = 1'b0; req_we = 1'b0; req_fn3 = '0; req_addr = '0; req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;

        // 1: aligned LW, then response held
        poke_word(BASE + 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, BASE + 32'h10, 32'd0, e, d, l);
        check_model("lw", 1'b0, 3'b010, BASE + 32'h10, 32'd0, e, d, l);
        check("lw_rdata_const", d, 32'hDEADBEEF);
        check("lw_lat_const", 32'(l), 32'd3);
        @(negedge clk);
        check("lw_pulse_one_cycle", 32'(resp_valid), 32'd0);
        check("lw_rdata_held", resp_rdata, 32'hDEADBEEF);

        // 2: LB / LBU on the top lane
        poke_word(BASE, 32'h80123456);
        do_req(1'b0, 3'b000, BASE + 32'h3, 32'd0, e, d, l);
        check_model("lb", 1'b0, 3'b000, BASE + 32'h3, 32'd0, e, d, l);
        check("lb_const", d, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, BASE + 32'h3, 32'd0, e, d, l);
        check_model("lbu", 1'b0, 3'b100, BASE + 32'h3, 32'd0, e, d, l);
        check("lbu_const", d, 32'h00000080);
        check("lbu_be", 32'(acc_q[acc_base].be), 32'b1000);

        // 3: split SW, exact lane-aligned write data
        do_req(1'b1, 3'b010, BASE + 32'h6, 32'h11223344, e, d, l);
        check_model("sw_split", 1'b1, 3'b010, BASE + 32'h6, 32'h11223344, e, d, l);
        check("sw_a0_addr", acc_q[acc_base].addr, 32'h8000_2004);
        check("sw_a0_wdata", acc_q[acc_base].wdata, 32'h33440000);
        check("sw_a1_addr", acc_q[acc_base + 1].addr, 32'h8000_2008);
        check("sw_a1_wdata", acc_q[acc_base + 1].wdata, 32'h00001122);

        // 4: split LH with grant held off for 3 cycles per access
        poke_word(BASE + 32'h4, 32'hAB000000);
        poke_word(BASE + 32'h8, 32'h000000CD);
        gnt_delay = 3;
        do_req(1'b0, 3'b001, BASE + 32'h7, 32'd0, e, d, l);
        check_model("lh_split", 1'b0, 3'b001, BASE + 32'h7, 32'd0, e, d, l);
        check("lh_split_const", d, 32'hFFFFCDAB);
        check("lh_stall_cycles", 32'(req_cnt - req_base), 32'd8);
        gnt_delay = 0;

        // 5: range and fn3 errors
        do_req(1'b0, 3'b010, 32'h8000_0000, 32'd0, e, d, l);
        check("oor_err", 32'(e), 32'd1);
        check("oor_lat", 32'(l), 32'd1);
        check("oor_no_req", 32'(req_cnt - req_base), 32'd0);
        do_req(1'b1, 3'b011, BASE, 32'hFFFF_FFFF, e, d, l);
        check("sb011_err", 32'(e), 32'd1);
        check("sb011_lat", 32'(l), 32'd1);
        check("sb011_no_req", 32'(req_cnt - req_base), 32'd0);

        // 6: grant never arrives, then read data never arrives
        gnt_delay = NEVER;
        do_req(1'b0, 3'b010, BASE + 32'h20, 32'd0, e, d, l);
        check("tmo_gnt_err", 32'(e), 32'd1);
        check("tmo_gnt_lat", 32'(l), 32'(TMO + 1));
        check("tmo_gnt_req_cycles", 32'(req_cnt - req_base), 32'(TMO));
        check("tmo_gnt_req_dropped", 32'(mem_req), 32'd0);
        check("tmo_gnt_rdata", d, 32'd0);
        gnt_delay = 0; rv_delay = NEVER;
        do_req(1'b0, 3'b010, BASE + 32'h20, 32'd0, e, d, l);
        check("tmo_rv_err", 32'(e), 32'd1);
        check("tmo_rv_lat", 32'(l), 32'(TMO + 2));
        rv_delay = 0;

        // Reset while waiting for read data
        poke_word(BASE + 32'h30, 32'h12345678);
        do_req(1'b0, 3'b010, BASE + 32'h30, 32'd0, e, d, l);
        check_model("pre_rst", 1'b0, 3'b010, BASE + 32'h30, 32'd0, e, d, l);
        rv_delay = NEVER;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_fn3 = 3'b010; req_addr = BASE + 32'h30;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_wait_mem_req", 32'(mem_req), 32'd0);
        check("rst_wait_mem_we", 32'(mem_we), 32'd0);
        check("rst_wait_mem_addr", mem_addr, 32'd0);
        check("rst_wait_mem_be", 32'(mem_be), 32'd0);
        check("rst_wait_mem_wdata", mem_wdata, 32'd0);
        check("rst_wait_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_wait_resp_err", 32'(resp_err), 32'd0);
        check("rst_wait_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv_delay = 0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            gnt_delay = $urandom_range(0, 2);
            rv_delay  = $urandom_range(0, 2);
            we = 1'($urandom);
            if ($urandom_range(0, 3) == 0) f = 3'($urandom);
            else if (we) f = 3'($urandom_range(0, 2));
            else begin
                f = 3'($urandom_range(0, 4));
                if (f == 3'd3) f = 3'd5;
            end
            case ($urandom_range(0, 5))
                0:       a = BASE + 32'($urandom_range(0, SIZE - 1));
                1:       a = BASE + 32'(SIZE) - 32'($urandom_range(1, 6));
                2:       a = BASE - 32'($urandom_range(1, 4));
                3:       a = $urandom;
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            wd = $urandom;
            do_req(we, f, a, wd, e, d, l);
            check_model("rand", we, f, a, wd, e, d, l);
        end

        check("hold_stable", 32'(stable_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
